// File: rtl/clk_div_gen_pkg.sv
// rtl/clk_div_gen_pkg.sv - shared width default and FSM state encoding for the clock divider
package clk_div_gen_pkg;

    localparam int DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BYPASS = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control and divided-clock signal bundle for clk_div_gen
interface clk_div_gen_if #(
    parameter int DIV_W = clk_div_gen_pkg::DIV_W_DEF
);

    logic             i_clk_en;
    logic [DIV_W-1:0] i_divide_ratio;
    logic             o_div_clk;
    logic             o_period_tick;
    logic             o_active;
    logic [DIV_W-1:0] o_ratio_cur;

    modport master (
        output i_clk_en,
        output i_divide_ratio,
        input  o_div_clk,
        input  o_period_tick,
        input  o_active,
        input  o_ratio_cur
    );

    modport slave (
        input  i_clk_en,
        input  i_divide_ratio,
        output o_div_clk,
        output o_period_tick,
        output o_active,
        output o_ratio_cur
    );

endinterface

// File: rtl/clk_div_halfcyc.sv
// rtl/clk_div_halfcyc.sv - negedge odd-ratio stretch and glitch-free bypass mux
module clk_div_halfcyc
    import clk_div_gen_pkg::*;
(
    input  logic   i_ref_clk,
    input  logic   i_rst,
    input  logic   div_q,
    input  logic   stretch_en,
    input  state_t state,
    output logic   div_clk
);

    logic neg_q;
    logic byp_sel;

    // Select only moves while i_ref_clk is low, so the mux never cuts a ref pulse.
    always_ff @(negedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            neg_q   <= 1'b0;
            byp_sel <= 1'b0;
        end else begin
            neg_q   <= div_q & stretch_en;
            byp_sel <= (state == ST_BYPASS);
        end
    end

    assign div_clk = byp_sel ? i_ref_clk : (div_q | neg_q);

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - parametrised integer clock divider with bypass and odd-ratio duty fix
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W        = DIV_W_DEF,
    parameter bit ODD_DUTY_FIX = 1'b1
) (
    input  logic         i_ref_clk,
    input  logic         i_rst,
    clk_div_gen_if.slave bus
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] ratio_in;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] k_half;
    logic             at_tc;
    logic             div_q;
    logic             tick_q;
    logic             active_q;
    logic             stretch_en;
    logic             div_clk;

    assign ratio_in   = (bus.i_divide_ratio == '0) ? ONE : bus.i_divide_ratio;
    assign at_tc      = (cnt == (ratio_q - ONE));
    assign cnt_inc    = cnt + ONE;
    assign k_half     = ratio_q >> 1;
    assign stretch_en = ODD_DUTY_FIX & ratio_q[0];

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ratio_q  <= '0;
            div_q    <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ratio_q  <= ratio_in;
                    cnt      <= '0;
                    div_q    <= 1'b0;
                    active_q <= 1'b0;
                    if (bus.i_clk_en) begin
                        if (ratio_in == ONE) begin
                            state <= ST_BYPASS;
                        end else begin
                            state    <= ST_RUN;
                            div_q    <= 1'b1;
                            tick_q   <= 1'b1;
                            active_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Ratio and enable are only honoured at the period boundary.
                    if (at_tc) begin
                        ratio_q <= ratio_in;
                        cnt     <= '0;
                        if (!bus.i_clk_en) begin
                            state    <= ST_IDLE;
                            div_q    <= 1'b0;
                            active_q <= 1'b0;
                        end else if (ratio_in == ONE) begin
                            state    <= ST_BYPASS;
                            div_q    <= 1'b0;
                            active_q <= 1'b0;
                        end else begin
                            div_q  <= 1'b1;
                            tick_q <= 1'b1;
                        end
                    end else begin
                        cnt   <= cnt_inc;
                        div_q <= (cnt_inc < k_half);
                    end
                end
                ST_BYPASS: begin
                    ratio_q  <= ratio_in;
                    cnt      <= '0;
                    div_q    <= 1'b0;
                    active_q <= 1'b0;
                    if (!bus.i_clk_en || (ratio_in != ONE)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    clk_div_halfcyc u_halfcyc (
        .i_ref_clk  (i_ref_clk),
        .i_rst      (i_rst),
        .div_q      (div_q),
        .stretch_en (stretch_en),
        .state      (state),
        .div_clk    (div_clk)
    );

    assign bus.o_div_clk     = div_clk;
    assign bus.o_period_tick = tick_q;
    assign bus.o_active      = active_q;
    assign bus.o_ratio_cur   = ratio_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - bench for clk_div_gen with ODD_DUTY_FIX=1 and =0 instances
module tb_clk_div_gen;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_BYP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] ratio = 8'd0;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_gen_if #(.DIV_W(8)) bus_f ();
    clk_div_gen_if #(.DIV_W(8)) bus_n ();

    assign bus_f.i_clk_en       = en;
    assign bus_f.i_divide_ratio = ratio;
    assign bus_n.i_clk_en       = en;
    assign bus_n.i_divide_ratio = ratio;

    clk_div_gen #(.DIV_W(8), .ODD_DUTY_FIX(1'b1)) dut_f (
        .i_ref_clk (clk),
        .i_rst     (rst),
        .bus       (bus_f)
    );

    clk_div_gen #(.DIV_W(8), .ODD_DUTY_FIX(1'b0)) dut_n (
        .i_ref_clk (clk),
        .i_rst     (rst),
        .bus       (bus_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: a period of R ref cycles is 2R half-cycles; the first
    // R (fix) or 2*floor(R/2) (no fix) halves are high.
    int m_mode  = M_IDLE;
    int m_pos   = 0;
    int m_ratio = 0;
    bit m_sel   = 1'b0;

    function automatic int high_halves(int r, bit fix);
        return fix ? r : 2 * (r / 2);
    endfunction

    function automatic int exp_div(bit fix, int half);
        if (m_sel) return (half == 0) ? 1 : 0;
        if (m_mode != M_RUN) return 0;
        return ((2 * m_pos + half) < high_halves(m_ratio, fix)) ? 1 : 0;
    endfunction

    function automatic void m_reset();
        m_mode  = M_IDLE;
        m_pos   = 0;
        m_ratio = 0;
        m_sel   = 1'b0;
    endfunction

    function automatic void m_step(bit e, int r_raw);
        int r;
        r = (r_raw == 0) ? 1 : r_raw;
        case (m_mode)
            M_IDLE: begin
                m_ratio = r;
                if (e) begin
                    m_mode = (r >= 2) ? M_RUN : M_BYP;
                    m_pos  = 0;
                end
            end
            M_BYP: begin
                m_ratio = r;
                if (!e || r >= 2) m_mode = M_IDLE;
            end
            default: begin
                if (m_pos == m_ratio - 1) begin
                    m_ratio = r;
                    m_pos   = 0;
                    if (!e) m_mode = M_IDLE;
                    else if (r == 1) m_mode = M_BYP;
                end else begin
                    m_pos++;
                end
            end
        endcase
    endfunction

    always begin
        @(posedge clk);
        if (rst) m_reset();
        else m_step(en, int'(ratio));
        #1;
        if (rst) m_reset();
        chk("div_hi_fix", int'(bus_f.o_div_clk), exp_div(1'b1, 0));
        chk("div_hi_nofix", int'(bus_n.o_div_clk), exp_div(1'b0, 0));
        chk("tick", int'(bus_f.o_period_tick), (m_mode == M_RUN && m_pos == 0) ? 1 : 0);
        chk("tick_nofix", int'(bus_n.o_period_tick), (m_mode == M_RUN && m_pos == 0) ? 1 : 0);
        chk("active", int'(bus_f.o_active), (m_mode == M_RUN) ? 1 : 0);
        chk("ratio_cur", int'(bus_f.o_ratio_cur), m_ratio);
        chk("ratio_cur_nofix", int'(bus_n.o_ratio_cur), m_ratio);
        @(negedge clk);
        m_sel = rst ? 1'b0 : (m_mode == M_BYP);
        #1;
        if (rst) m_reset();
        chk("div_lo_fix", int'(bus_f.o_div_clk), exp_div(1'b1, 1));
        chk("div_lo_nofix", int'(bus_n.o_div_clk), exp_div(1'b0, 1));
    end

    typedef struct packed {
        logic       hf;
        logic       lf;
        logic       hn;
        logic       ln;
        logic       tick;
        logic       act;
        logic [7:0] rc;
    } samp_t;

    typedef struct {
        int ratio;
        int win;
        int ticks;
        int hi_fix;
        int hi_nofix;
        int act;
        int rc;
    } vec_t;

    task automatic sample(output samp_t s);
        @(posedge clk);
        #1;
        s.hf   = bus_f.o_div_clk;
        s.hn   = bus_n.o_div_clk;
        s.tick = bus_f.o_period_tick;
        s.act  = bus_f.o_active;
        s.rc   = bus_f.o_ratio_cur;
        @(negedge clk);
        #1;
        s.lf = bus_f.o_div_clk;
        s.ln = bus_n.o_div_clk;
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        en    = 1'b0;
        ratio = 8'd0;
        rst   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_pos(input int p, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (m_mode == M_RUN && m_pos == p) found = 1'b1;
            else step(1);
        end
        if (!found) chk(name, 0, 1);
    endtask

    vec_t  vecs[8];
    samp_t s;

    initial begin
        int hf_cnt, hn_cnt, tk_cnt, act_cnt, n, rc_prev;
        bit got;

        vecs[0] = '{4,   4,   1, 4,   4,   1, 4};
        vecs[1] = '{5,   5,   1, 5,   4,   1, 5};
        vecs[2] = '{2,   2,   1, 2,   2,   1, 2};
        vecs[3] = '{3,   3,   1, 3,   2,   1, 3};
        vecs[4] = '{8,   8,   1, 8,   8,   1, 8};
        vecs[5] = '{255, 255, 1, 255, 254, 1, 255};
        vecs[6] = '{1,   4,   0, 4,   4,   0, 1};
        vecs[7] = '{0,   4,   0, 4,   4,   0, 1};

        step(2);
        do_reset();

        foreach (vecs[v]) begin
            do_reset();
            en    = 1'b1;
            ratio = 8'(vecs[v].ratio);
            if (vecs[v].ticks == 0) begin
                repeat (3) sample(s);
            end else begin
                got = 1'b0;
                for (int i = 0; i < 600 && !got; i++) begin
                    sample(s);
                    if (s.tick) got = 1'b1;
                end
                if (!got) chk("vec_tick_timeout", 0, 1);
            end
            hf_cnt = 0; hn_cnt = 0; tk_cnt = 0;
            for (int c = 0; c < vecs[v].win; c++) begin
                if (c > 0 || vecs[v].ticks == 0) sample(s);
                hf_cnt += int'(s.hf) + int'(s.lf);
                hn_cnt += int'(s.hn) + int'(s.ln);
                tk_cnt += int'(s.tick);
            end
            chk($sformatf("vec%0d_hi_fix", v), hf_cnt, vecs[v].hi_fix);
            chk($sformatf("vec%0d_hi_nofix", v), hn_cnt, vecs[v].hi_nofix);
            chk($sformatf("vec%0d_ticks", v), tk_cnt, vecs[v].ticks);
            chk($sformatf("vec%0d_active", v), int'(s.act), vecs[v].act);
            chk($sformatf("vec%0d_ratio_cur", v), int'(s.rc), vecs[v].rc);
        end

        // Ratio 4 -> 6 requested at cnt=1
        do_reset();
        en = 1'b1; ratio = 8'd4;
        wait_pos(1, "r46_wait");
        ratio = 8'd6;
        n = 0; rc_prev = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            sample(s); n++;
            if (s.tick) got = 1'b1; else rc_prev = int'(s.rc);
        end
        chk("r46_gap1", n, 3);
        chk("r46_rc_before", rc_prev, 4);
        chk("r46_rc_after", int'(s.rc), 6);
        n = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            sample(s); n++;
            if (s.tick) got = 1'b1;
        end
        chk("r46_gap2", n, 6);

        // Enable drop at cnt=1 of R=8
        do_reset();
        en = 1'b1; ratio = 8'd8;
        wait_pos(1, "endrop_wait");
        en = 1'b0;
        act_cnt = 0; hf_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            sample(s);
            act_cnt += int'(s.act);
            hf_cnt  += int'(s.hf) + int'(s.lf);
        end
        chk("endrop_active_cycles", act_cnt, 6);
        chk("endrop_high_halves", hf_cnt, 4);
        chk("endrop_final_out", int'(s.hf), 0);

        // Disable and ratio change together at terminal count
        do_reset();
        en = 1'b1; ratio = 8'd4;
        wait_pos(3, "tcdis_wait");
        en = 1'b0; ratio = 8'd6;
        sample(s);
        chk("tcdis_active", int'(s.act), 0);
        chk("tcdis_ratio_cur", int'(s.rc), 6);
        chk("tcdis_out", int'(s.hf), 0);
        chk("tcdis_tick", int'(s.tick), 0);

        // Async reset in the high phase of R=255
        do_reset();
        en = 1'b1; ratio = 8'd255;
        wait_pos(50, "rst255_wait");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst255_div_fix", int'(bus_f.o_div_clk), 0);
        chk("rst255_div_nofix", int'(bus_n.o_div_clk), 0);
        chk("rst255_active", int'(bus_f.o_active), 0);
        chk("rst255_ratio_cur", int'(bus_f.o_ratio_cur), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        sample(s);
        chk("rst255_restart_div", int'(s.hf), 1);
        chk("rst255_restart_tick", int'(s.tick), 1);
        chk("rst255_restart_rc", int'(s.rc), 255);

        // Randomised traffic checked by the model
        do_reset();
        for (int it = 0; it < 500; it++) begin
            en = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 9))
                0: ratio = 8'd0;
                1: ratio = 8'd1;
                2: ratio = 8'd2;
                3: ratio = 8'd3;
                4: ratio = 8'd4;
                5: ratio = 8'd5;
                6: ratio = 8'd7;
                7: ratio = 8'd6;
                8: ratio = 8'($urandom_range(2, 20));
                default: ratio = 8'($urandom_range(0, 40));
            endcase
            step($urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
